// File: rtl/spi_multi_cs_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_multi_cs_master
// Purpose  : SPI master with chip-select decode, multi-word frames and a
//            per-frame CPOL/CPHA selection.
// Revision : 1.0 - initial release
// ============================================================================
module spi_multi_cs_master #(
    parameter int NUM_SLAVES        = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_WORDS_PER_CS  = 4,
    parameter int CS_SETUP_CLKS     = 1,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = $clog2(MAX_WORDS_PER_CS + 1),
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic [CW-1:0]         i_TX_Count,
    input  logic [SW-1:0]         i_Slave_Sel,
    input  logic [1:0]            i_SPI_Mode,
    input  logic [DATA_WIDTH-1:0] TX_Word,
    input  logic                  TX_valid,
    output logic                  TX_ready,
    output logic                  RX_valid,
    output logic [DATA_WIDTH-1:0] RX_Word,
    output logic [CW-1:0]         o_RX_Count,
    output logic                  o_Busy,
    output logic                  o_Err,
    output logic                  SPI_Clk,
    input  logic                  SPI_MISO,
    output logic                  SPI_MOSI,
    output logic [NUM_SLAVES-1:0] SPI_CS_n
);

    localparam int C_MAXT_A = (CS_SETUP_CLKS > CLKS_PER_HALF_BIT) ? CS_SETUP_CLKS : CLKS_PER_HALF_BIT;
    localparam int C_MAXT   = (C_MAXT_A > CS_INACTIVE_CLKS) ? C_MAXT_A : CS_INACTIVE_CLKS;
    localparam int TW       = $clog2(C_MAXT + 1);
    localparam int ECW      = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [TW-1:0]         C_SETUP_LAST = TW'(CS_SETUP_CLKS - 1);
    localparam logic [TW-1:0]         C_HALF_LAST  = TW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [TW-1:0]         C_INACT_LAST = TW'(CS_INACTIVE_CLKS);
    localparam logic [ECW-1:0]        C_EDGE_LAST  = ECW'(2 * DATA_WIDTH - 1);
    localparam logic [CW-1:0]         C_MAX_WORDS  = CW'(MAX_WORDS_PER_CS);
    localparam logic [NUM_SLAVES-1:0] C_CS_IDLE    = '1;
    localparam logic [NUM_SLAVES-1:0] C_CS_ONE     = NUM_SLAVES'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT    = 3'd2,
        S_NEXT     = 3'd3,
        S_CS_INACT = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TW-1:0]           r_tmr;
    logic [ECW-1:0]          r_edge_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_word;
    logic [CW-1:0]           r_words_left;
    logic [CW-1:0]           r_rx_count;
    logic [1:0]              r_mode;
    logic [NUM_SLAVES-1:0]   r_cs_n;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_rx_valid;
    logic                    r_err;

    logic w_tx_ready;
    logic w_xfer;
    logic w_req_bad;
    logic w_start;
    logic w_bad;
    logic w_load;
    logic w_ld_cpha;
    logic w_tick;
    logic w_lead;
    logic w_last;
    logic w_sample;
    logic w_shift;

    // Ready is gated by the reset pin so it reads 0 while reset is held.
    assign w_tx_ready = reset & ((r_state == S_IDLE) | (r_state == S_NEXT));
    assign w_xfer     = TX_valid & w_tx_ready;
    assign w_req_bad  = (i_TX_Count == '0) || (i_TX_Count > C_MAX_WORDS) ||
                        ({{(32-SW){1'b0}}, i_Slave_Sel} >= 32'(NUM_SLAVES));

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bad       = 1'b0;
        w_load      = 1'b0;
        w_ld_cpha   = r_mode[0];
        w_tick      = (r_state == S_SHIFT) && (r_tmr == C_HALF_LAST);
        w_lead      = (r_edge_cnt[0] == 1'b0);
        w_last      = w_tick && (r_edge_cnt == C_EDGE_LAST);
        // CPHA=0 samples on leading toggles, CPHA=1 on trailing ones.
        w_sample    = w_tick && (r_mode[0] ? !w_lead : w_lead);
        w_shift     = w_tick && (r_mode[0] ? w_lead : (!w_lead && !w_last));
        case (r_state)
            S_IDLE: begin
                w_ld_cpha = i_SPI_Mode[0];
                if (w_xfer) begin
                    if (w_req_bad) begin
                        w_bad = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (r_tmr == C_SETUP_LAST) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = (r_words_left == CW'(1)) ? S_CS_INACT : S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_CS_INACT: begin
                if (r_tmr == C_INACT_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_tmr        <= '0;
            r_edge_cnt   <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_rx_word    <= '0;
            r_words_left <= '0;
            r_rx_count   <= '0;
            r_mode       <= 2'b00;
            r_cs_n       <= C_CS_IDLE;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= w_bad;

            if ((r_state != w_state_nxt) || w_tick) begin
                r_tmr <= '0;
            end else if ((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_CS_INACT)) begin
                r_tmr <= r_tmr + TW'(1);
            end

            if (w_start) begin
                r_mode       <= i_SPI_Mode;
                r_words_left <= i_TX_Count;
                r_rx_count   <= '0;
                r_cs_n       <= ~(C_CS_ONE << i_Slave_Sel);
                r_sclk       <= i_SPI_Mode[1];
            end

            // Leaving CS low through the RX_valid cycle; it rises one cycle later.
            if (r_state == S_CS_INACT) begin
                r_cs_n <= C_CS_IDLE;
            end

            if (w_load) begin
                r_edge_cnt <= '0;
                if (!w_ld_cpha) begin
                    r_mosi     <= TX_Word[DATA_WIDTH-1];
                    r_tx_shift <= {TX_Word[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    r_tx_shift <= TX_Word;
                end
            end

            if (w_tick) begin
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= r_edge_cnt + ECW'(1);
            end

            if (w_shift) begin
                r_mosi     <= r_tx_shift[DATA_WIDTH-1];
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], SPI_MISO};
            end

            if (w_last) begin
                r_rx_valid <= 1'b1;
                r_rx_word  <= r_mode[0] ? {r_rx_shift[DATA_WIDTH-2:0], SPI_MISO} : r_rx_shift;
                if (r_words_left != '0) begin
                    r_words_left <= r_words_left - CW'(1);
                end
                if (r_rx_count != C_MAX_WORDS) begin
                    r_rx_count <= r_rx_count + CW'(1);
                end
            end
        end
    end

    assign TX_ready   = w_tx_ready;
    assign RX_valid   = r_rx_valid;
    assign RX_Word    = r_rx_word;
    assign o_RX_Count = r_rx_count;
    assign o_Busy     = (r_state != S_IDLE);
    assign o_Err      = r_err;
    assign SPI_Clk    = r_sclk;
    assign SPI_MOSI   = r_mosi;
    assign SPI_CS_n   = r_cs_n;

endmodule
`default_nettype wire
